// File: rtl/ps2_move_scheduler.sv
// ps2_move_scheduler
// Turns PS/2 scan-code bytes into single-cycle game move pulses.
// A prefix decoder (IDLE/EXT/BRK/EXT_BRK) classifies each byte as a make,
// a break or a protocol error. It tracks which of the four game keys are
// held and keeps one pending request bit per key. A fixed-priority arbiter
// (rotate > down > left > right) grants one pending request per cycle
// while move_ready is high.
//
// Optional feature macro: PS2_AUTOREPEAT_EN. When it is defined, held
// left/right/down keys re-request after REPEAT_DELAY cycles and then every
// REPEAT_PERIOD cycles. Rotate never auto-repeats.
//
// Ports
//   CLOCK_50     in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   ps2_data     in   [7:0] received byte
//   ps2_data_en  in   ps2_data valid this cycle
//   move_ready   in   game logic accepts a move this cycle
//   rotate/left/right/down  out  registered one-cycle move pulses
//   keys_held    out  [3:0] {down, right, left, rotate}
//   protocol_err out  registered one-cycle pulse on an illegal prefix
module ps2_move_scheduler #(
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] ps2_data,
  input  logic       ps2_data_en,
  input  logic       move_ready,
  output logic       rotate,
  output logic       left,
  output logic       right,
  output logic       down,
  output logic [3:0] keys_held,
  output logic       protocol_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] make_s;
  logic [3:0] brk_s;
  logic       err_s;
  logic [3:0] new_make_s;
  logic [3:0] rpt_set_s;
  logic [3:0] grant_s;
  logic [3:0] pending_r;

  // Key index: [0] rotate, [1] left, [2] right, [3] down
  function automatic logic [3:0] key_onehot(input logic [7:0] code);
    logic [3:0] k;
    case (code)
      8'h75:   k = 4'b0001;
      8'h6B:   k = 4'b0010;
      8'h74:   k = 4'b0100;
      8'h72:   k = 4'b1000;
      default: k = 4'b0000;
    endcase
    return k;
  endfunction

  // Prefix decoder: next state and make/break/error classification
  always_comb begin
    state_nxt_s = state_r;
    make_s      = 4'b0000;
    brk_s       = 4'b0000;
    err_s       = 1'b0;
    if (ps2_data_en) begin
      case (state_r)
        IDLE: begin
          if (ps2_data == 8'hE0) begin
            state_nxt_s = EXT;
          end else if (ps2_data == 8'hF0) begin
            state_nxt_s = BRK;
          end else begin
            make_s = key_onehot(ps2_data);
          end
        end
        EXT: begin
          if (ps2_data == 8'hF0) begin
            state_nxt_s = EXT_BRK;
          end else if (ps2_data == 8'hE0) begin
            err_s       = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            make_s      = key_onehot(ps2_data);
            state_nxt_s = IDLE;
          end
        end
        BRK, EXT_BRK: begin
          if ((ps2_data == 8'hE0) || (ps2_data == 8'hF0)) begin
            err_s = 1'b1;
          end else begin
            brk_s = key_onehot(ps2_data);
          end
          state_nxt_s = IDLE;
        end
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Decoder state register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Keyboard typematic makes of an already-held key are dropped here
  assign new_make_s = make_s & ~keys_held;

`ifdef PS2_AUTOREPEAT_EN
  localparam logic [23:0] DELAY_LD  = 24'(REPEAT_DELAY);
  localparam logic [23:0] PERIOD_LD = 24'(REPEAT_PERIOD);

  // Counters for left/right/down only; slot i-1 belongs to key index i
  logic [2:0][23:0] cnt_r;

  // A counter about to reach zero on this edge raises a repeat request
  always_comb begin
    rpt_set_s = 4'b0000;
    for (int i = 1; i < 4; i++) begin
      rpt_set_s[i] = keys_held[i] && (cnt_r[i-1] == 24'd1);
    end
  end

  // Repeat counters: load on make, clear on break, reload on expiry
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= '0;
    end else begin
      for (int i = 1; i < 4; i++) begin
        if (brk_s[i]) begin
          cnt_r[i-1] <= 24'd0;
        end else if (new_make_s[i]) begin
          cnt_r[i-1] <= DELAY_LD;
        end else if (rpt_set_s[i]) begin
          cnt_r[i-1] <= PERIOD_LD;
        end else if (keys_held[i] && (cnt_r[i-1] != 24'd0)) begin
          cnt_r[i-1] <= cnt_r[i-1] - 24'd1;
        end else begin
          cnt_r[i-1] <= cnt_r[i-1];
        end
      end
    end
  end
`else
  assign rpt_set_s = 4'b0000;
`endif

  // Fixed-priority grant: rotate > down > left > right
  always_comb begin
    grant_s = 4'b0000;
    if (move_ready) begin
      if (pending_r[0]) begin
        grant_s = 4'b0001;
      end else if (pending_r[3]) begin
        grant_s = 4'b1000;
      end else if (pending_r[1]) begin
        grant_s = 4'b0010;
      end else if (pending_r[2]) begin
        grant_s = 4'b0100;
      end else begin
        grant_s = 4'b0000;
      end
    end else begin
      grant_s = 4'b0000;
    end
  end

  // Held keys, pending requests (a new set beats a same-edge grant) and outputs
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      keys_held    <= 4'b0000;
      pending_r    <= 4'b0000;
      rotate       <= 1'b0;
      left         <= 1'b0;
      right        <= 1'b0;
      down         <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      keys_held    <= (keys_held | new_make_s) & ~brk_s;
      pending_r    <= (pending_r & ~grant_s) | new_make_s | rpt_set_s;
      rotate       <= grant_s[0];
      left         <= grant_s[1];
      right        <= grant_s[2];
      down         <= grant_s[3];
      protocol_err <= err_s;
    end
  end

endmodule

// File: tb/tb_ps2_move_scheduler.sv
// tb_ps2_move_scheduler
// Directed bench for ps2_move_scheduler with REPEAT_DELAY=10 and
// REPEAT_PERIOD=4. The auto-repeat sequence is exercised only when
// PS2_AUTOREPEAT_EN is defined. Inputs are driven and outputs sampled
// on the falling clock edge.
module tb_ps2_move_scheduler;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] ps2_data;
  logic       ps2_data_en;
  logic       move_ready;
  logic       rotate, left, right, down;
  logic [3:0] keys_held;
  logic       protocol_err;

  int total = 0;
  int bad   = 0;
  int c_rot, c_left, c_right, c_down, c_err, c_multi;

  always #10 clk = ~clk;

  ps2_move_scheduler #(
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(4)
  ) dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .ps2_data    (ps2_data),
    .ps2_data_en (ps2_data_en),
    .move_ready  (move_ready),
    .rotate      (rotate),
    .left        (left),
    .right       (right),
    .down        (down),
    .keys_held   (keys_held),
    .protocol_err(protocol_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    c_rot = 0; c_left = 0; c_right = 0; c_down = 0; c_err = 0;
  endtask

  // Advance to the next falling edge and tally the outputs seen there
  task automatic tick();
    @(negedge clk);
    c_rot   += int'(rotate);
    c_left  += int'(left);
    c_right += int'(right);
    c_down  += int'(down);
    c_err   += int'(protocol_err);
    if ($countones({rotate, left, right, down}) > 1) c_multi++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    ps2_data    = b;
    ps2_data_en = 1'b1;
    tick();
    ps2_data_en = 1'b0;
    ps2_data    = 8'h00;
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    ps2_data_en = 1'b0;
    move_ready  = 1'b0;
    ticks(2);
    resetn = 1'b1;
    clr_counts();
  endtask

  initial begin
    logic [31:0] pat;
    c_multi     = 0;
    clr_counts();
    resetn      = 1'b0;
    ps2_data    = 8'h00;
    ps2_data_en = 1'b0;
    move_ready  = 1'b0;

    // Reset values before any clock edge
    #5;
    check_val("rst_keys", {28'd0, keys_held}, 32'h0);
    check_val("rst_moves", {28'd0, rotate, left, right, down}, 32'h0);
    check_val("rst_err", {31'd0, protocol_err}, 32'h0);

    // E0,6B -> one left pulse two edges after the 6B byte
    do_reset();
    move_ready = 1'b1;
    send_byte(8'hE0);
    send_byte(8'h6B);
    check_val("ext_left_t0", {31'd0, left}, 32'h0);
    tick();
    check_val("ext_left_t1", {31'd0, left}, 32'h1);
    tick();
    check_val("ext_left_t2", {31'd0, left}, 32'h0);
    check_val("ext_left_held", {28'd0, keys_held}, 32'h2);
    send_byte(8'hF0);
    send_byte(8'h6B);
    ticks(15);
    check_val("ext_left_count", c_left, 1);
    check_val("ext_left_rel", {28'd0, keys_held}, 32'h0);

    // 75 x4 then F0,75 -> exactly one rotate
    do_reset();
    move_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'h75);
    send_byte(8'hF0);
    send_byte(8'h75);
    ticks(6);
    check_val("typ_rot_count", c_rot, 1);
    check_val("typ_rot_rel", {31'd0, keys_held[0]}, 32'h0);
    ticks(20);
    check_val("typ_rot_after", c_rot, 1);

    // Held requests drained in priority order rotate, down, left
    do_reset();
    send_byte(8'h6B);
    send_byte(8'h75);
    send_byte(8'h72);
    ticks(3);
    check_val("prio_none", c_rot + c_left + c_right + c_down, 0);
    check_val("prio_held", {28'd0, keys_held}, 32'hB);
    move_ready = 1'b1;
    tick();
    check_val("prio_1_rot", {28'd0, rotate, left, right, down}, 32'h8);
    tick();
    check_val("prio_2_down", {28'd0, rotate, left, right, down}, 32'h1);
    tick();
    check_val("prio_3_left", {28'd0, rotate, left, right, down}, 32'h4);
    tick();
    check_val("prio_4_idle", {28'd0, rotate, left, right, down}, 32'h0);

    // Break keeps the pending request; it is served later
    do_reset();
    send_byte(8'h74);
    send_byte(8'hF0);
    send_byte(8'h74);
    check_val("brk_rel", {28'd0, keys_held}, 32'h0);
    move_ready = 1'b1;
    ticks(3);
    check_val("brk_pending", c_right, 1);

    // Set and grant of the same key on one edge leaves it pending
    do_reset();
    send_byte(8'h6B);
    send_byte(8'hF0);
    send_byte(8'h6B);
    move_ready = 1'b1;
    send_byte(8'h6B);
    ticks(4);
    check_val("set_wins", c_left, 2);

    // Protocol errors, then decoding resumes from IDLE
    do_reset();
    move_ready = 1'b1;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'hE0);
    ticks(2);
    check_val("err_ext_brk", c_err, 1);
    send_byte(8'h72);
    ticks(2);
    check_val("err_next_down", c_down, 1);
    check_val("err_next_held", {28'd0, keys_held}, 32'h8);
    send_byte(8'hE0);
    send_byte(8'hE0);
    ticks(1);
    check_val("err_ext_ext", c_err, 2);
    send_byte(8'h75);
    ticks(2);
    check_val("err_next_rot", c_rot, 1);

`ifdef PS2_AUTOREPEAT_EN
    // Auto-repeat of right: pulses at make+1, +11, +15, +19, stop on break
    do_reset();
    move_ready = 1'b1;
    send_byte(8'h74);
    pat = 32'h0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      pat[i] = right;
    end
    check_val("rpt_pattern", pat, 32'h0008_8802);
    clr_counts();
    send_byte(8'hF0);
    send_byte(8'h74);
    ticks(12);
    check_val("rpt_stop", c_right, 0);
`endif

    // Reset while left is held and pending
    do_reset();
    send_byte(8'h6B);
    ticks(2);
    check_val("rh_held", {28'd0, keys_held}, 32'h2);
    resetn = 1'b0;
    #1;
    check_val("rh_async", {28'd0, keys_held}, 32'h0);
    ticks(3);
    resetn     = 1'b1;
    move_ready = 1'b1;
    clr_counts();
    ticks(20);
    check_val("rh_no_left", c_left, 0);
    check_val("rh_keys", {28'd0, keys_held}, 32'h0);
    send_byte(8'h6B);
    ticks(3);
    check_val("rh_new_make", c_left, 1);

    check_val("onehot", c_multi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/ps2_move_scheduler.md
PS2_MOVE_SCHEDULER -- requirements
Module: ps2_move_scheduler

Interface
REQ-001 The block SHALL have parameter REPEAT_DELAY, default 12_500_000, meaning the number of cycles from key make to the first auto-repeat request.
REQ-002 The block SHALL have parameter REPEAT_PERIOD, default 5_000_000, meaning the number of cycles between later auto-repeat requests.
REQ-003 The block SHALL have port CLOCK_50, input, 1 bit: the single system clock; all state SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port ps2_data, input, 8 bits: byte received from the PS/2 controller.
REQ-006 The block SHALL have port ps2_data_en, input, 1 bit: ps2_data is valid this cycle; it SHALL be consumed exactly once.
REQ-007 The block SHALL have port move_ready, input, 1 bit: the game logic can accept a move this cycle.
REQ-008 The block SHALL have ports rotate, left, right and down, each output, 1 bit: registered one-cycle move pulses.
REQ-009 The block SHALL have port keys_held, output, 4 bits, bit order [0] rotate, [1] left, [2] right, [3] down.
REQ-010 The block SHALL have port protocol_err, output, 1 bit: registered one-cycle pulse on an illegal prefix sequence.

Function
REQ-011 Key map: 0x75 SHALL map to rotate, 0x6B to left, 0x74 to right and 0x72 to down, with or without an E0 prefix; all other codes SHALL be ignored.
REQ-012 Decoder FSM states SHALL be IDLE, EXT, BRK and EXT_BRK; a transition SHALL occur only on a cycle with ps2_data_en=1.
REQ-013 In IDLE: E0 SHALL go to EXT, F0 SHALL go to BRK, and any other byte SHALL be a make code that stays in IDLE.
REQ-014 In EXT: F0 SHALL go to EXT_BRK; any other byte SHALL be a make code and go to IDLE.
REQ-015 In BRK and EXT_BRK: E0 or F0 SHALL pulse protocol_err and go to IDLE; any other byte SHALL be a break code and go to IDLE.
REQ-016 In EXT, a repeated E0 SHALL pulse protocol_err and go to IDLE.
REQ-017 A make of a key not held SHALL set its keys_held bit and its pending bit, and SHALL load that key's repeat counter with REPEAT_DELAY.
REQ-018 A make of a key already held (keyboard typematic) SHALL be ignored.
REQ-019 A break SHALL clear the key's keys_held bit only; its pending bit SHALL be retained.
REQ-020 Arbiter: on an edge with move_ready=1 and any pending bit set, exactly one output SHALL pulse high in the next cycle, and that key's pending bit SHALL be cleared.
REQ-021 Arbiter priority SHALL be rotate > down > left > right.
REQ-022 With move_ready=0, pending bits SHALL be held and all move outputs SHALL be 0.
REQ-023 Back-to-back grants on consecutive cycles SHALL be allowed.
REQ-024 If a pending bit is set and granted on the same edge, the set SHALL win and the bit SHALL stay pending.
REQ-025 Pending SHALL be one bit per key, so multiple unserved requests for one key SHALL collapse into one.
REQ-026 At most one move output SHALL be high in any cycle.

Reset
REQ-027 While resetn=0, the FSM SHALL be IDLE and all outputs, keys_held, pending bits and repeat counters SHALL be 0, with no clock required.
REQ-028 Reset mid-sequence (after E0 or F0) SHALL discard the partial prefix; the next byte after reset SHALL be decoded from IDLE.

Configuration
REQ-029 With PS2_AUTOREPEAT_EN defined, each held left, right or down key SHALL decrement its own 24-bit counter every cycle; on reaching 0 it SHALL set the pending bit and reload REPEAT_PERIOD.
REQ-030 With PS2_AUTOREPEAT_EN defined, rotate SHALL never auto-repeat, and a break SHALL stop its key's counter immediately.
REQ-031 Without PS2_AUTOREPEAT_EN, no repeat counters SHALL exist and each key SHALL produce exactly one request per make.

Verification
REQ-032 Bench SHALL check: move_ready=1, bytes E0,6B -> left=1 for exactly one cycle, two edges after the 6B byte; keys_held=4'b0010.
REQ-033 Bench SHALL check: 75, then 75 three more times, then F0,75 -> exactly one rotate pulse; keys_held[0] returns to 0; no further pulses.
REQ-034 Bench SHALL check: move_ready=0, makes 6B,75,72 -> no pulses; move_ready raised -> rotate, down, left on three consecutive cycles.
REQ-035 Bench SHALL check, with PS2_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=4, move_ready=1: hold 74 -> right pulses at make+1, +11, +15, +19; F0,74 -> pulses stop.
REQ-036 Bench SHALL check: bytes E0,F0,E0 -> protocol_err pulses once, FSM is IDLE; the following 72 decodes as a down make.
REQ-037 Bench SHALL check: hold 6B, assert resetn=0 mid-hold for 3 cycles -> keys_held=0 and no left pulse after release until a new make.
